fixed_divide_hs: RTL and testbench
==================================

Name: fixed_divide_hs

Overview:
- Iterative signed fixed-point divider for the ray tracer datapath (ray/plane t-values, reciprocal normals).
- Successor to the single-radix divide unit. Adds:
  - a ready/valid handshake on both sides, with back-to-back issue;
  - selectable bits-per-cycle;
  - rounding mode per operation;
  - saturation and divide-by-zero flags;
  - a tag that passes through with each operation.
- Computes quotient = dividend * 2^Q_BITS / divisor. Both operands and the result are signed two's complement with Q_BITS fractional bits.

Parameters:
- D_WIDTH, 32, operand and result width.
- Q_BITS, 10, fractional bits. Must satisfy 0 <= Q_BITS < D_WIDTH.
- BITS_PER_CYCLE, 1, quotient bits resolved per CALC cycle. Legal values: 1, 2, 4.
- TAG_WIDTH, 8, width of the opaque sideband tag.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands are valid.
- in_ready  out  1  divider can accept an operation.
- dividend  in  D_WIDTH  signed numerator.
- divisor  in  D_WIDTH  signed denominator.
- round_en  in  1  1 = round half away from zero; 0 = truncate toward zero.
- in_tag  in  TAG_WIDTH  sideband tag, returned with the result.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- quotient  out  D_WIDTH  signed result.
- out_tag  out  TAG_WIDTH  tag captured at accept.
- div_by_zero  out  1  divisor was 0.
- overflow  out  1  result was saturated because the quotient magnitude exceeded the range.

Behaviour:
- Reset (asynchronous, active-high; clock clock) forces:
  - state IDLE;
  - out_valid, quotient, out_tag, div_by_zero, overflow all 0;
  - internal magnitude, sign, round and iteration registers cleared.
- Reset mid-operation discards the operation. No output is produced for it.
- States and transitions:
  - IDLE: accept when in_valid && in_ready, then go to CALC.
  - CALC: run ITER steps, then go to DONE.
  - DONE: hold the result until out_ready. If in_valid is also high, go to CALC with the new operands; otherwise go to IDLE.
- Handshake:
  - in_ready = (state==IDLE) || (state==DONE && out_ready). This is a combinational path from out_ready; it is intentional.
  - Operands, round_en and in_tag are sampled only on an accept edge.
  - Outputs stay stable while out_valid && !out_ready.
  - A result is consumed on an edge where out_valid && out_ready.
- Arithmetic:
  - Capture at accept: sign = dividend[MSB] ^ divisor[MSB]; dz = (divisor==0); dneg = dividend[MSB].
  - Magnitudes |dividend| and |divisor| are unsigned D_WIDTH bits, so 2^(D_WIDTH-1) is legal.
  - Numerator N = (|dividend| << Q_BITS) + (round_en ? |divisor|>>1 : 0), width NW = D_WIDTH+Q_BITS+1.
  - Restoring division over NW bits, zero-extended to ITER*BITS_PER_CYCLE, MSB first.
  - ITER = ceil(NW/BITS_PER_CYCLE). Each CALC edge resolves BITS_PER_CYCLE bits.
  - The remainder register is D_WIDTH+1 bits. It is never output.
- Result formation, on the final CALC edge, with Qm = unsigned quotient magnitude:
  - dz: quotient = dneg ? 1<<(D_WIDTH-1) : 2^(D_WIDTH-1)-1; div_by_zero=1; overflow=0. Iteration still runs, so latency is constant.
  - !sign && Qm > 2^(D_WIDTH-1)-1: quotient = max positive; overflow=1.
  - sign && Qm > 2^(D_WIDTH-1): quotient = min negative; overflow=1.
  - Otherwise quotient = sign ? -Qm : Qm.
  - Negative zero yields 0.
- Latency:
  - Accept at edge k; out_valid rises after edge k+ITER.
  - Defaults give 43 cycles.
  - Throughput is one result per ITER cycles under continuous out_ready.

Test Plan:
1. Defaults, round_en=0, 3072/2048 (3.0/2.0), tag 0x5A, out_ready=1:
   - quotient=1536, out_tag=0x5A, flags 0;
   - out_valid exactly 43 cycles after accept;
   - in_ready low during CALC.
2. Rounding and signs, 2048/3072:
   - round_en=0 gives 682; round_en=1 gives 683;
   - -2048/3072 gives -682 / -683;
   - 2048/-3072 and -2048/-3072 give -682 and 682 (truncate).
3. Divide by zero:
   - 5120/0 gives 0x7FFFFFFF, div_by_zero=1;
   - -5120/0 gives 0x80000000;
   - 0/0 gives 0x7FFFFFFF;
   - overflow=0 in all three.
4. Saturation boundary, divisor=1:
   - dividend 0x00200000 gives 0x7FFFFFFF, overflow=1;
   - dividend 0xFFE00000 gives 0x80000000, overflow=0;
   - dividend 0x40000000 gives 0x7FFFFFFF, overflow=1.
5. Backpressure:
   - hold out_ready=0 for 10 cycles after out_valid: quotient and tag stable, in_ready=0;
   - then raise out_ready with in_valid=1 on the same cycle: new op accepted on that edge with no idle bubble; its result appears 43 cycles later with its own tag.
6. Reset and mode:
   - assert reset at CALC cycle 20: out_valid=0 immediately, in_ready=1 after release, no stray result;
   - repeat test 1 with BITS_PER_CYCLE=4: latency 11 cycles, identical quotient.

Source files
------------

// File: rtl/fixed_divide_hs_if.sv
// Handshake bundle for the fixed-point divider.
//   master: operand producer / result consumer (drives in_* and out_ready)
//   slave : the divider (drives in_ready and the result signals)
interface fixed_divide_hs_if #(
    parameter int D_WIDTH   = 32,
    parameter int TAG_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [D_WIDTH-1:0]   dividend;
    logic [D_WIDTH-1:0]   divisor;
    logic                 round_en;
    logic [TAG_WIDTH-1:0] in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [D_WIDTH-1:0]   quotient;
    logic [TAG_WIDTH-1:0] out_tag;
    logic                 div_by_zero;
    logic                 overflow;

    modport master (
        output in_valid, dividend, divisor, round_en, in_tag, out_ready,
        input  in_ready, out_valid, quotient, out_tag, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, round_en, in_tag, out_ready,
        output in_ready, out_valid, quotient, out_tag, div_by_zero, overflow
    );
endinterface

// File: rtl/fixed_divide_hs.sv
// Iterative signed fixed-point divider: quotient = dividend * 2^Q_BITS / divisor.
// Restoring division on magnitudes, BITS_PER_CYCLE quotient bits per CALC cycle,
// optional round-half-away-from-zero, saturation and divide-by-zero flags.
// Ports:
//   clock, reset - rising-edge clock, asynchronous active-high reset
//   bus          - slave side of fixed_divide_hs_if (operands/tag in, result/flags out)
module fixed_divide_hs #(
    parameter int D_WIDTH        = 32,
    parameter int Q_BITS         = 10,
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_WIDTH      = 8
) (
    input  logic               clock,
    input  logic               reset,
    fixed_divide_hs_if.slave   bus
);
    localparam int NW   = D_WIDTH + Q_BITS + 1;
    localparam int ITER = (NW + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
    localparam int TOT  = ITER * BITS_PER_CYCLE;
    localparam int RW   = D_WIDTH + 1;
    localparam int CW   = $clog2(ITER + 1);

    localparam logic [D_WIDTH-1:0] MAX_POS = {1'b0, {(D_WIDTH-1){1'b1}}};
    localparam logic [D_WIDTH-1:0] MIN_NEG = {1'b1, {(D_WIDTH-1){1'b0}}};
    localparam logic [TOT-1:0]     MAX_EXT = TOT'(MAX_POS);
    localparam logic [TOT-1:0]     MIN_EXT = TOT'(MIN_NEG);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state, state_nx;
    logic [TOT-1:0]       shreg;      // numerator bits shift out the top, quotient bits shift in the bottom
    logic [RW-1:0]        rem;
    logic [D_WIDTH-1:0]   dmag;
    logic                 sign, dz, dneg;
    logic [CW-1:0]        cnt;
    logic [TAG_WIDTH-1:0] tag_pend;
    logic [D_WIDTH-1:0]   quot_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 dz_q, ovf_q;

    logic                 accept, last;
    logic [D_WIDTH-1:0]   a_mag, b_mag;
    logic [NW-1:0]        num;
    logic [TOT-1:0]       sh_nx;
    logic [RW-1:0]        rem_nx;
    logic [RW:0]          t;
    logic [D_WIDTH-1:0]   res_q;
    logic                 res_ovf;

    assign bus.in_ready    = (state == IDLE) || (state == DONE && bus.out_ready);
    assign bus.out_valid   = (state == DONE);
    assign bus.quotient    = quot_q;
    assign bus.out_tag     = tag_q;
    assign bus.div_by_zero = dz_q;
    assign bus.overflow    = ovf_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign last   = (cnt == CW'(ITER - 1));

    // Magnitudes are unsigned, so the most negative operand maps to 2^(D_WIDTH-1).
    assign a_mag = bus.dividend[D_WIDTH-1] ? (D_WIDTH'(0) - bus.dividend) : bus.dividend;
    assign b_mag = bus.divisor[D_WIDTH-1]  ? (D_WIDTH'(0) - bus.divisor)  : bus.divisor;
    assign num   = (NW'(a_mag) << Q_BITS) + (bus.round_en ? NW'(b_mag >> 1) : NW'(0));

    // BITS_PER_CYCLE restoring steps. rem stays below dmag, so t never needs its top bit after subtract.
    always_comb begin
        sh_nx  = shreg;
        rem_nx = rem;
        t      = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            t     = {rem_nx, sh_nx[TOT-1]};
            sh_nx = sh_nx << 1;
            if (t >= {2'b00, dmag}) begin
                t        = t - {2'b00, dmag};
                sh_nx[0] = 1'b1;
            end
            rem_nx = t[RW-1:0];
        end
    end

    // Sign/saturation on the completed magnitude; the negative range reaches one further.
    always_comb begin
        res_q   = '0;
        res_ovf = 1'b0;
        if (dz) begin
            res_q = dneg ? MIN_NEG : MAX_POS;
        end else if (!sign && sh_nx > MAX_EXT) begin
            res_q   = MAX_POS;
            res_ovf = 1'b1;
        end else if (sign && sh_nx > MIN_EXT) begin
            res_q   = MIN_NEG;
            res_ovf = 1'b1;
        end else begin
            res_q = sign ? (D_WIDTH'(0) - sh_nx[D_WIDTH-1:0]) : sh_nx[D_WIDTH-1:0];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = CALC;
            CALC: if (last) state_nx = DONE;
            DONE: if (bus.out_ready) state_nx = bus.in_valid ? CALC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            rem      <= '0;
            dmag     <= '0;
            sign     <= 1'b0;
            dz       <= 1'b0;
            dneg     <= 1'b0;
            cnt      <= '0;
            tag_pend <= '0;
            quot_q   <= '0;
            tag_q    <= '0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                shreg    <= TOT'(num);
                rem      <= '0;
                dmag     <= b_mag;
                sign     <= bus.dividend[D_WIDTH-1] ^ bus.divisor[D_WIDTH-1];
                dz       <= (bus.divisor == '0);
                dneg     <= bus.dividend[D_WIDTH-1];
                cnt      <= '0;
                tag_pend <= bus.in_tag;
            end else if (state == CALC) begin
                shreg <= sh_nx;
                rem   <= rem_nx;
                cnt   <= cnt + 1'b1;
                if (last) begin
                    quot_q <= res_q;
                    tag_q  <= tag_pend;
                    dz_q   <= dz;
                    ovf_q  <= res_ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_fixed_divide_hs.sv
module tb_fixed_divide_hs;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    fixed_divide_hs_if #(.D_WIDTH(32), .TAG_WIDTH(8)) bus1 ();
    fixed_divide_hs_if #(.D_WIDTH(32), .TAG_WIDTH(8)) bus4 ();

    fixed_divide_hs #(.D_WIDTH(32), .Q_BITS(10), .BITS_PER_CYCLE(1), .TAG_WIDTH(8)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1));
    fixed_divide_hs #(.D_WIDTH(32), .Q_BITS(10), .BITS_PER_CYCLE(4), .TAG_WIDTH(8)) dut4 (
        .clock(clock), .reset(reset), .bus(bus4));

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Waits for out_valid on dut1, returns cycles counted since the accept edge.
    task automatic wait_valid1(output int cyc);
        cyc = 0;
        while (bus1.out_valid !== 1'b1 && cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
        end
    endtask

    // One operation on dut1 with out_ready held high; called at #1 after an edge with dut1 idle.
    task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic rnd, input logic [7:0] tg, input logic [31:0] eq,
                         input logic edz, input logic eovf);
        int cyc;
        bus1.dividend = a;
        bus1.divisor  = b;
        bus1.round_en = rnd;
        bus1.in_tag   = tg;
        bus1.in_valid = 1'b1;
        @(posedge clock); #1;
        bus1.in_valid = 1'b0;
        check({name, "_busy"}, {63'd0, bus1.in_ready}, 64'd0);
        wait_valid1(cyc);
        check({name, "_lat"}, 64'(cyc), 64'd43);
        check({name, "_q"}, {32'd0, bus1.quotient}, {32'd0, eq});
        check({name, "_tag"}, {56'd0, bus1.out_tag}, {56'd0, tg});
        check({name, "_flags"}, {62'd0, bus1.div_by_zero, bus1.overflow}, {62'd0, edz, eovf});
        @(posedge clock); #1;
    endtask

    initial begin
        logic [31:0] q0;
        logic [7:0]  t0;
        logic        ok;
        int          cyc;

        bus1.in_valid = 1'b0; bus1.dividend = '0; bus1.divisor = '0;
        bus1.round_en = 1'b0; bus1.in_tag = '0;   bus1.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.dividend = '0; bus4.divisor = '0;
        bus4.round_en = 1'b0; bus4.in_tag = '0;   bus4.out_ready = 1'b1;

        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", {63'd0, bus1.out_valid}, 64'd0);
        check("rst_q", {32'd0, bus1.quotient}, 64'd0);
        check("rst_tag_flags", {54'd0, bus1.out_tag, bus1.div_by_zero, bus1.overflow}, 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        check("rst_ready", {63'd0, bus1.in_ready}, 64'd1);

        // basic divide
        do_op("t1", 32'd3072, 32'd2048, 1'b0, 8'h5A, 32'd1536, 1'b0, 1'b0);

        // rounding and signs
        do_op("r_pp_t", 32'd2048,      32'd3072,      1'b0, 8'h01, 32'd682,       1'b0, 1'b0);
        do_op("r_pp_r", 32'd2048,      32'd3072,      1'b1, 8'h02, 32'd683,       1'b0, 1'b0);
        do_op("r_np_t", 32'hFFFFF800,  32'd3072,      1'b0, 8'h03, 32'hFFFFFD56,  1'b0, 1'b0);
        do_op("r_np_r", 32'hFFFFF800,  32'd3072,      1'b1, 8'h04, 32'hFFFFFD55,  1'b0, 1'b0);
        do_op("r_pn_t", 32'd2048,      32'hFFFFF400,  1'b0, 8'h05, 32'hFFFFFD56,  1'b0, 1'b0);
        do_op("r_nn_t", 32'hFFFFF800,  32'hFFFFF400,  1'b0, 8'h06, 32'd682,       1'b0, 1'b0);

        // divide by zero
        do_op("dz_pos",  32'd5120,     32'd0, 1'b0, 8'h10, 32'h7FFFFFFF, 1'b1, 1'b0);
        do_op("dz_neg",  32'hFFFFEC00, 32'd0, 1'b0, 8'h11, 32'h80000000, 1'b1, 1'b0);
        do_op("dz_zero", 32'd0,        32'd0, 1'b1, 8'h12, 32'h7FFFFFFF, 1'b1, 1'b0);

        // saturation boundary
        do_op("sat_pos",  32'h00200000, 32'd1, 1'b0, 8'h20, 32'h7FFFFFFF, 1'b0, 1'b1);
        do_op("sat_neg",  32'hFFE00000, 32'd1, 1'b0, 8'h21, 32'h80000000, 1'b0, 1'b0);
        do_op("sat_big",  32'h40000000, 32'd1, 1'b0, 8'h22, 32'h7FFFFFFF, 1'b0, 1'b1);

        // backpressure then back-to-back accept from DONE
        bus1.out_ready = 1'b0;
        bus1.dividend = 32'd3072; bus1.divisor = 32'd2048; bus1.round_en = 1'b0;
        bus1.in_tag = 8'h77; bus1.in_valid = 1'b1;
        @(posedge clock); #1;
        bus1.in_valid = 1'b0;
        wait_valid1(cyc);
        check("bp_lat", 64'(cyc), 64'd43);
        q0 = bus1.quotient;
        t0 = bus1.out_tag;
        ok = 1'b1;
        repeat (10) begin
            @(posedge clock); #1;
            if (bus1.quotient !== q0 || bus1.out_tag !== t0 ||
                bus1.out_valid !== 1'b1 || bus1.in_ready !== 1'b0) ok = 1'b0;
        end
        check("bp_stable", {63'd0, ok}, 64'd1);
        check("bp_q_tag", {24'd0, q0, t0}, {24'd0, 32'd1536, 8'h77});
        bus1.out_ready = 1'b1;
        bus1.dividend = 32'd2048; bus1.divisor = 32'd3072; bus1.round_en = 1'b1;
        bus1.in_tag = 8'h88; bus1.in_valid = 1'b1;
        #1;
        check("bp_ready_comb", {63'd0, bus1.in_ready}, 64'd1);
        @(posedge clock); #1;
        bus1.in_valid = 1'b0;
        check("bp_accepted", {62'd0, bus1.out_valid, bus1.in_ready}, 64'd0);
        wait_valid1(cyc);
        check("bp2_lat", 64'(cyc), 64'd43);
        check("bp2_q_tag", {24'd0, bus1.quotient, bus1.out_tag}, {24'd0, 32'd683, 8'h88});
        @(posedge clock); #1;

        // reset in the middle of CALC
        bus1.dividend = 32'd3072; bus1.divisor = 32'd2048; bus1.round_en = 1'b0;
        bus1.in_tag = 8'h99; bus1.in_valid = 1'b1;
        @(posedge clock); #1;
        bus1.in_valid = 1'b0;
        repeat (19) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {63'd0, bus1.out_valid}, 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("mid_rst_ready", {63'd0, bus1.in_ready}, 64'd1);
        ok = 1'b1;
        repeat (60) begin
            @(posedge clock); #1;
            if (bus1.out_valid !== 1'b0) ok = 1'b0;
        end
        check("mid_rst_nostray", {63'd0, ok}, 64'd1);
        do_op("post_rst", 32'd3072, 32'd2048, 1'b0, 8'h5A, 32'd1536, 1'b0, 1'b0);

        // 4 bits per cycle
        bus4.dividend = 32'd3072; bus4.divisor = 32'd2048; bus4.round_en = 1'b0;
        bus4.in_tag = 8'h5A; bus4.in_valid = 1'b1;
        @(posedge clock); #1;
        bus4.in_valid = 1'b0;
        check("b4_busy", {63'd0, bus4.in_ready}, 64'd0);
        cyc = 0;
        while (bus4.out_valid !== 1'b1 && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
        end
        check("b4_lat", 64'(cyc), 64'd11);
        check("b4_q_tag", {24'd0, bus4.quotient, bus4.out_tag}, {24'd0, 32'd1536, 8'h5A});
        check("b4_flags", {62'd0, bus4.div_by_zero, bus4.overflow}, 64'd0);
        @(posedge clock); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
